arbx_gea0: RTL and testbench



---
 rtl/arbx_gea0_pkg.sv | 23 ++
 rtl/arbx_gea0_ffsx.sv | 40 ++++
 rtl/arbx_gea0.sv | 82 ++++++++
 tb/tb_arbx_gea0.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/arbx_gea0_pkg.sv
// Shared generic-cell definitions: arbiter state encoding and the ceil-log2
// helper used to size index ports.
package arbx_gea0_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_e;

  // Elaboration-time ceil(log2(n)); callers guarantee n >= 2.
  function automatic int clog2_f(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/arbx_gea0_ffsx.sv
// Rotating find-first-set: lowest set bit of vec searching start, start+1, ...
// wrapping modulo SIZE. Purely combinational.
module ffsx_gea0
  import arbx_gea0_pkg::*;
#(
  parameter int SIZE = 2,
  localparam int IDXW = clog2_f(SIZE)
) (
  input  logic [SIZE-1:0] vec,
  input  logic [IDXW-1:0] start,
  output logic            found,
  output logic [IDXW-1:0] idx
);

  localparam logic [IDXW:0] SIZE_W = (IDXW+1)'(SIZE);

  logic [2*SIZE-1:0] dbl;
  logic [SIZE-1:0]   rot;
  logic [IDXW-1:0]   off;
  logic [IDXW:0]     sum;
  logic [IDXW:0]     wrap;

  // Rotate so that bit 0 is the start position, then take the lowest set bit.
  always_comb begin
    dbl   = {vec, vec} >> start;
    rot   = dbl[SIZE-1:0];
    found = 1'b0;
    off   = '0;
    for (int k = SIZE - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = IDXW'(k);
      end
    end
    sum  = {1'b0, start} + {1'b0, off};
    wrap = sum - SIZE_W;
    idx  = (sum >= SIZE_W) ? wrap[IDXW-1:0] : sum[IDXW-1:0];
  end

endmodule

// File: rtl/arbx_gea0.sv
// Round-robin arbiter with a registered one-hot grant held until the owner
// releases (done pulse or request withdrawal).
module arbx_gea0
  import arbx_gea0_pkg::*;
#(
  parameter int SIZE = 2,
  localparam int IDXW = clog2_f(SIZE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] req,
  input  logic            done,
  output logic [SIZE-1:0] gnt,
  output logic            gnt_vld,
  output logic [IDXW-1:0] gnt_idx,
  output logic            busy
);

  localparam logic [SIZE-1:0] ONE  = SIZE'(1);
  localparam logic [IDXW-1:0] LAST = IDXW'(SIZE - 1);

  state_e          state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [SIZE-1:0] gnt_q, gnt_d;
  logic [IDXW-1:0] gnt_idx_q, gnt_idx_d;

  logic            win_found;
  logic [IDXW-1:0] win_idx;
  logic            release_w;
  logic            arb_w;

  ffsx_gea0 #(.SIZE(SIZE)) u_ffs (
    .vec   (req),
    .start (ptr_q),
    .found (win_found),
    .idx   (win_idx)
  );

  // ptr always sits one past the owner, so a releasing owner that still
  // requests is naturally last in the search order.
  assign release_w = (state_q == OWNED) && (done || !req[gnt_idx_q]);
  assign arb_w     = (state_q == IDLE) || release_w;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    if (arb_w) begin
      if (win_found) begin
        state_d   = OWNED;
        gnt_d     = ONE << win_idx;
        gnt_idx_d = win_idx;
        ptr_d     = (win_idx == LAST) ? '0 : win_idx + IDXW'(1);
      end else begin
        state_d   = IDLE;
        gnt_d     = '0;
        gnt_idx_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_vld = (state_q == OWNED);
  assign gnt_idx = gnt_idx_q;
  assign busy    = (|req) | gnt_vld;

endmodule

// File: tb/tb_arbx_gea0.sv
// Bench for arbx_gea0 (SIZE=4): directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_arbx_gea0;

  localparam int SIZE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [3:0] gnt;
  logic       gnt_vld;
  logic [1:0] gnt_idx;
  logic       busy;

  int checks = 0;
  int errors = 0;

  arbx_gea0 #(.SIZE(SIZE)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Model state: who owns the resource and where the next search begins.
  int m_owned = 0;
  int m_idx   = 0;
  int m_ptr   = 0;
  int m_rel;
  int m_win;

  // Build the search order from ptr; a releasing owner that still requests
  // is moved to the very end of the rotation.
  function automatic int pick_winner(input logic [3:0] r, input int ptr,
                                     input int still_req, input int owner);
    int order[$];
    for (int k = 0; k < SIZE; k++) begin
      if (!(still_req != 0 && ((ptr + k) % SIZE) == owner))
        order.push_back((ptr + k) % SIZE);
    end
    if (still_req != 0) order.push_back(owner);
    foreach (order[j]) begin
      if (r[order[j]]) return order[j];
    end
    return -1;
  endfunction

  always_comb begin
    m_rel = (m_owned != 0 && (done || !req[m_idx])) ? 1 : 0;
    m_win = pick_winner(req, m_ptr, (m_rel != 0 && req[m_idx]) ? 1 : 0, m_idx);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owned <= 0;
      m_idx   <= 0;
      m_ptr   <= 0;
    end else if (m_owned == 0 || m_rel != 0) begin
      if (m_win >= 0) begin
        m_owned <= 1;
        m_idx   <= m_win;
        m_ptr   <= (m_win + 1) % SIZE;
      end else begin
        m_owned <= 0;
        m_idx   <= 0;
      end
    end
  end

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    compare("model_gnt", 32'(gnt), (m_owned != 0) ? 32'(1) << m_idx : 32'd0);
    compare("model_gnt_vld", 32'(gnt_vld), 32'(m_owned != 0));
    compare("model_gnt_idx", 32'(gnt_idx), (m_owned != 0) ? 32'(m_idx) : 32'd0);
    compare("model_busy", 32'(busy), 32'((|req) || m_owned != 0));
  end

  task automatic applyStimulus(input logic [3:0] r, input logic d);
    req  = r;
    done = d;
  endtask

  // Crosses one rising edge, then checks literal expectations on the negedge.
  task automatic checkOutput(input logic [3:0] exp_gnt, input logic exp_busy, input string name);
    int exp_idx;
    exp_idx = 0;
    for (int i = 0; i < SIZE; i++) if (exp_gnt[i]) exp_idx = i;
    @(negedge clk);
    compare({name, "_gnt"}, 32'(gnt), 32'(exp_gnt));
    compare({name, "_vld"}, 32'(gnt_vld), 32'(|exp_gnt));
    compare({name, "_idx"}, 32'(gnt_idx), 32'(exp_idx));
    compare({name, "_busy"}, 32'(busy), 32'(exp_busy));
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    req  = 4'b1111;
    done = 1'b0;
    @(negedge clk);
    compare("reset_gnt", 32'(gnt), 32'd0);
    compare("reset_idx", 32'(gnt_idx), 32'd0);
    compare("reset_busy", 32'(busy), 32'd1);
    #1;
    rst = 1'b0;
    applyStimulus(4'b1111, 1'b0);
    checkOutput(4'b0001, 1'b1, "first_grant");

    applyStimulus(4'b1111, 1'b1);
    checkOutput(4'b0010, 1'b1, "rr1");
    checkOutput(4'b0100, 1'b1, "rr2");
    checkOutput(4'b1000, 1'b1, "rr3");
    checkOutput(4'b0001, 1'b1, "rr4");

    applyStimulus(4'b0110, 1'b1);
    checkOutput(4'b0010, 1'b1, "hold_win");
    applyStimulus(4'b0110, 1'b0);
    for (int n = 0; n < 10; n++) checkOutput(4'b0010, 1'b1, "hold");

    applyStimulus(4'b0100, 1'b1);
    checkOutput(4'b0100, 1'b1, "own2");
    applyStimulus(4'b0001, 1'b0);
    checkOutput(4'b0001, 1'b1, "withdraw_wrap");
    applyStimulus(4'b1010, 1'b1);
    checkOutput(4'b0010, 1'b1, "ptr_after_wrap");

    applyStimulus(4'b0100, 1'b1);
    checkOutput(4'b0100, 1'b1, "sole_first");
    checkOutput(4'b0100, 1'b1, "sole_regrant");
    applyStimulus(4'b0000, 1'b0);
    checkOutput(4'b0000, 1'b0, "idle");

    applyStimulus(4'b1000, 1'b0);
    checkOutput(4'b1000, 1'b1, "own3");
    #1;
    rst = 1'b1;
    #1;
    compare("async_rst_gnt", 32'(gnt), 32'd0);
    compare("async_rst_vld", 32'(gnt_vld), 32'd0);
    applyStimulus(4'b1010, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    checkOutput(4'b0010, 1'b1, "after_rst");

    for (int n = 0; n < 500; n++) begin
      req  = (req & 4'($urandom)) | 4'($urandom & $urandom);
      done = ($urandom_range(0, 2) == 0);
      rst  = ($urandom_range(0, 60) == 0);
      @(negedge clk);
      #1;
    end
    rst = 1'b0;
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
